// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - preamble hunt, subframe framing and frame_dismantle supervision
// Optional feature macro: FRAME_SEQ_ERRCNT_EN (adds saturating err_count output)
module frame_sequencer #(
  parameter int         TIMEOUT = 1024,
  parameter logic [3:0] PRE_B   = 4'b1110,
  parameter logic [3:0] PRE_M   = 4'b0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        dis_kill,
  input  logic        dis_done,
  output logic        dis_rst,
  output logic        dis_vin,
  output logic        dis_din,
  output logic [7:0]  frame_counter,
  output logic        locked,
  output logic [15:0] block_count
`ifdef FRAME_SEQ_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT, BODY, PRE} state_t;

  state_t          state;
  logic [3:0]      sr;
  logic [4:0]      body_cnt;
  logic [1:0]      pre_cnt;
  logic [IW-1:0]   idle_cnt;

  logic [3:0] next_sr;
  logic [3:0] exp_pre;
  logic       timeout;
  logic       pre_bad;
  logic       err_evt;

  // The preamble register is shared by the hunt and by preamble collection.
  assign next_sr = {sr[2:0], bit_in};
  // frame_counter has already advanced on the first preamble bit, so it names the frame being opened.
  assign exp_pre = (frame_counter == 8'd0) ? PRE_B : PRE_M;
  assign timeout = (state != HUNT) && (idle_cnt == IW'(TIMEOUT));
  assign pre_bad = (state == PRE) && bit_valid && (pre_cnt == 2'd3) && (next_sr != exp_pre);
  // Kill, mismatch and timeout collapse into a single error event; kill is ignored while hunting.
  assign err_evt = (state != HUNT) && (dis_kill || timeout || pre_bad);

  // Framing FSM with registered outputs toward frame_dismantle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HUNT;
      sr            <= 4'd0;
      body_cnt      <= 5'd0;
      pre_cnt       <= 2'd0;
      dis_rst       <= 1'b0;
      dis_vin       <= 1'b0;
      dis_din       <= 1'b0;
      frame_counter <= 8'd0;
      locked        <= 1'b0;
    end else begin
      dis_rst <= 1'b0;
      dis_vin <= 1'b0;
      if (err_evt) begin
        state         <= HUNT;
        locked        <= 1'b0;
        dis_rst       <= 1'b1;
        frame_counter <= 8'd0;
        sr            <= 4'd0;
      end else if (bit_valid) begin
        case (state)
          HUNT: begin
            sr <= next_sr;
            if (next_sr == PRE_B) begin
              dis_rst       <= 1'b1;
              frame_counter <= 8'd0;
              locked        <= 1'b1;
              state         <= BODY;
              body_cnt      <= 5'd0;
            end
          end
          BODY: begin
            dis_vin  <= 1'b1;
            dis_din  <= bit_in;
            body_cnt <= body_cnt + 5'd1;
            if (body_cnt == 5'd27) begin
              state   <= PRE;
              pre_cnt <= 2'd0;
            end
          end
          PRE: begin
            sr      <= next_sr;
            pre_cnt <= pre_cnt + 2'd1;
            if (pre_cnt == 2'd0)
              frame_counter <= (frame_counter == 8'd191) ? 8'd0 : frame_counter + 8'd1;
            if (pre_cnt == 2'd3) begin
              state    <= BODY;
              body_cnt <= 5'd0;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // Idle watchdog: counts bit-less cycles only while aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt <= '0;
    else if (state == HUNT || bit_valid || err_evt)
      idle_cnt <= '0;
    else if (idle_cnt != IW'(TIMEOUT))
      idle_cnt <= idle_cnt + IW'(1);
  end

  // Completed blocks reported by frame_dismantle, counted regardless of error events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      block_count <= 16'd0;
    else if (dis_done)
      block_count <= block_count + 16'd1;
  end

`ifdef FRAME_SEQ_ERRCNT_EN
  // Saturating count of error events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= 8'd0;
    else if (err_evt && err_count != 8'd255)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer
module tb_frame_sequencer;

  localparam logic [3:0] PB = 4'b1110;
  localparam logic [3:0] PM = 4'b0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        dis_kill = 1'b0;
  logic        dis_done = 1'b0;
  logic        dis_rst;
  logic        dis_vin;
  logic        dis_din;
  logic [7:0]  frame_counter;
  logic        locked;
  logic [15:0] block_count;
`ifdef FRAME_SEQ_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  frame_sequencer dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .dis_kill(dis_kill), .dis_done(dis_done), .dis_rst(dis_rst),
    .dis_vin(dis_vin), .dis_din(dis_din), .frame_counter(frame_counter),
    .locked(locked), .block_count(block_count)
`ifdef FRAME_SEQ_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rst_pulses = 0;
  int vin_cycles = 0;
  int gap = 0;
  int exp_err = 0;
  int sb[$];

  // Samples #1 after each edge; every forwarded bit is popped against the expected (frame, bit).
  task automatic sample();
    int e;
    if (dis_rst) rst_pulses++;
    if (dis_vin) begin
      vin_cycles++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_vin got din=%0d fc=%0d required no strobe", dis_din, frame_counter);
      end else begin
        e = sb.pop_front();
        if (int'(frame_counter) * 2 + int'(dis_din) !== e) begin
          bad++;
          $display("FAIL sb_body_bit got fc=%0d din=%0d required fc=%0d din=%0d",
                   frame_counter, dis_din, e / 2, e % 2);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic send_bit(input logic b);
    repeat (gap) tick();
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] p);
    for (int i = 3; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic send_body(input int f, input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      sb.push_back(f * 2 + int'(b));
      send_bit(b);
    end
  endtask

  task automatic send_frame(input int f);
    send_nib((f == 0) ? PB : PM);
    send_body(f, 28);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (dis_rst !== 1'b0) begin bad++; $display("FAIL reset_dis_rst got %0d required 0", dis_rst); end
    total++; if (dis_vin !== 1'b0) begin bad++; $display("FAIL reset_dis_vin got %0d required 0", dis_vin); end
    total++; if (dis_din !== 1'b0) begin bad++; $display("FAIL reset_dis_din got %0d required 0", dis_din); end
    total++; if (frame_counter !== 8'd0) begin bad++; $display("FAIL reset_fc got %0d required 0", frame_counter); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got %0d required 0", locked); end
    total++; if (block_count !== 16'd0) begin bad++; $display("FAIL reset_blocks got %0d required 0", block_count); end
`ifdef FRAME_SEQ_ERRCNT_EN
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err got %0d required 0", err_count); end
`endif
  endtask

  task automatic test_clean_lock();
    rst_pulses = 0;
    vin_cycles = 0;
    send_frame(0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_locked got %0d required 1", locked); end
    for (int f = 1; f < 192; f++) send_frame(f);
    total++; if (rst_pulses !== 1) begin bad++; $display("FAIL lock_rst_pulses got %0d required 1", rst_pulses); end
    total++; if (vin_cycles !== 5376) begin bad++; $display("FAIL lock_vin_cycles got %0d required 5376", vin_cycles); end
    total++; if (frame_counter !== 8'd191) begin bad++; $display("FAIL lock_fc_end got %0d required 191", frame_counter); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL lock_sb_left got %0d required 0", sb.size()); end
    dis_done = 1'b1;
    tick();
    dis_done = 1'b0;
    total++; if (block_count !== 16'd1) begin bad++; $display("FAIL lock_block_count got %0d required 1", block_count); end
  endtask

  task automatic test_frame_wrap();
    send_bit(PB[3]);
    total++; if (frame_counter !== 8'd0) begin bad++; $display("FAIL wrap_fc got %0d required 0", frame_counter); end
    send_bit(PB[2]);
    send_bit(PB[1]);
    send_bit(PB[0]);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL wrap_locked got %0d required 1", locked); end
    total++; if (rst_pulses !== 1) begin bad++; $display("FAIL wrap_rst_pulses got %0d required 1", rst_pulses); end
    send_body(0, 28);
  endtask

  task automatic test_bad_preamble();
    int r0;
    int v0;
    for (int f = 1; f < 5; f++) send_frame(f);
    r0 = rst_pulses;
    send_nib(PB);
    exp_err++;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL badpre_locked got %0d required 0", locked); end
    total++; if (frame_counter !== 8'd0) begin bad++; $display("FAIL badpre_fc got %0d required 0", frame_counter); end
    total++; if (rst_pulses !== r0 + 1) begin bad++; $display("FAIL badpre_rst_pulses got %0d required %0d", rst_pulses, r0 + 1); end
`ifdef FRAME_SEQ_ERRCNT_EN
    total++; if (int'(err_count) !== exp_err) begin bad++; $display("FAIL badpre_err got %0d required %0d", err_count, exp_err); end
`endif
    v0 = vin_cycles;
    repeat (8) send_bit(1'b0);
    total++; if (vin_cycles !== v0) begin bad++; $display("FAIL badpre_hunt_vin got %0d required %0d", vin_cycles, v0); end
    send_frame(0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL badpre_relock got %0d required 1", locked); end
    total++; if (rst_pulses !== r0 + 2) begin bad++; $display("FAIL badpre_relock_rst got %0d required %0d", rst_pulses, r0 + 2); end
  endtask

  task automatic test_kill();
    int r0;
    for (int f = 1; f < 100; f++) send_frame(f);
    send_nib(PM);
    send_body(100, 10);
    r0 = rst_pulses;
    dis_kill = 1'b1;
    send_bit(1'b1);
    dis_kill = 1'b0;
    exp_err++;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL kill_locked got %0d required 0", locked); end
    total++; if (frame_counter !== 8'd0) begin bad++; $display("FAIL kill_fc got %0d required 0", frame_counter); end
    total++; if (dis_vin !== 1'b0) begin bad++; $display("FAIL kill_vin got %0d required 0", dis_vin); end
    total++; if (rst_pulses !== r0 + 1) begin bad++; $display("FAIL kill_rst_pulses got %0d required %0d", rst_pulses, r0 + 1); end
    dis_kill = 1'b1;
    repeat (6) send_bit(1'b0);
    dis_kill = 1'b0;
    total++; if (rst_pulses !== r0 + 1) begin bad++; $display("FAIL kill_hunt_ignored got %0d required %0d", rst_pulses, r0 + 1); end
    send_frame(0);
    r0 = rst_pulses;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    dis_kill = 1'b1;
    send_bit(1'b0);
    dis_kill = 1'b0;
    exp_err++;
    tick();
    total++; if (rst_pulses !== r0 + 1) begin bad++; $display("FAIL kill_mismatch_rst got %0d required %0d", rst_pulses, r0 + 1); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL kill_mismatch_locked got %0d required 0", locked); end
`ifdef FRAME_SEQ_ERRCNT_EN
    total++; if (int'(err_count) !== exp_err) begin bad++; $display("FAIL kill_err got %0d required %0d", err_count, exp_err); end
`endif
  endtask

  task automatic test_sparse_timeout();
    int v0;
    v0 = vin_cycles;
    gap = 2;
    for (int f = 0; f < 4; f++) send_frame(f);
    gap = 0;
    total++; if (vin_cycles !== v0 + 112) begin bad++; $display("FAIL sparse_vin got %0d required %0d", vin_cycles, v0 + 112); end
    total++; if (frame_counter !== 8'd3) begin bad++; $display("FAIL sparse_fc got %0d required 3", frame_counter); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL sparse_sb_left got %0d required 0", sb.size()); end
    repeat (1024) tick();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL timeout_early got locked=%0d required 1", locked); end
    tick();
    exp_err++;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL timeout_locked got %0d required 0", locked); end
    total++; if (dis_rst !== 1'b1) begin bad++; $display("FAIL timeout_dis_rst got %0d required 1", dis_rst); end
`ifdef FRAME_SEQ_ERRCNT_EN
    total++; if (int'(err_count) !== exp_err) begin bad++; $display("FAIL timeout_err got %0d required %0d", err_count, exp_err); end
`endif
  endtask

  task automatic test_reset_mid_body();
    send_nib(PB);
    send_body(0, 12);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    rst       = 1'b1;
    #2;
    total++; if (dis_rst !== 1'b0) begin bad++; $display("FAIL midrst_dis_rst got %0d required 0", dis_rst); end
    total++; if (dis_vin !== 1'b0) begin bad++; $display("FAIL midrst_dis_vin got %0d required 0", dis_vin); end
    total++; if (dis_din !== 1'b0) begin bad++; $display("FAIL midrst_dis_din got %0d required 0", dis_din); end
    total++; if (frame_counter !== 8'd0) begin bad++; $display("FAIL midrst_fc got %0d required 0", frame_counter); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_locked got %0d required 0", locked); end
    total++; if (block_count !== 16'd0) begin bad++; $display("FAIL midrst_blocks got %0d required 0", block_count); end
`ifdef FRAME_SEQ_ERRCNT_EN
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL midrst_err got %0d required 0", err_count); end
`endif
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bit_valid = 1'b0;
    send_nib(PM);
    send_nib(PM);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_no_relock got %0d required 0", locked); end
    send_nib(PB);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL midrst_relock got %0d required 1", locked); end
    send_body(0, 28);
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL midrst_sb_left got %0d required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_frame_wrap();
    test_bad_preamble();
    test_kill();
    test_sparse_timeout();
    test_reset_mid_body();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Sits between the bit-recovery front end and `frame_dismantle` and tracks its frame and subframe state. It hunts the serial bit stream for a block-start preamble, then strips each 4-bit preamble and forwards the 28 body bits with `vin` framing and a stable `frame_counter` (0..191). It supervises `frame_dismantle` through its `kill`/`done` outputs and resynchronises it with a one-cycle reset on any framing or CRC failure.

## Interface
- `TIMEOUT`, default 1024: number of cycles without `bit_valid` while locked before lock is dropped.
- `PRE_B`, default 4'b1110: block-start preamble, frame 0, MSB received first.
- `PRE_M`, default 4'b0010: preamble for frames 1..191.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `bit_valid` in 1: `bit_in` is valid this cycle.
- `bit_in` in 1: recovered serial bit.
- `dis_kill` in 1: `kill` from `frame_dismantle`.
- `dis_done` in 1: `done` from `frame_dismantle`.
- `dis_rst` out 1: one-cycle synchronous reset pulse to `frame_dismantle`, ORed with `rst` at the instantiation.
- `dis_vin` out 1: body-bit strobe, to `vin`.
- `dis_din` out 1: body bit, to `din`.
- `frame_counter` out 8: current frame index 0..191.
- `locked` out 1: sequencer is aligned to the stream.
- `block_count` out 16: number of completed blocks, wraps.

## Operation
- Reset value of every output is 0. Internal state after reset: HUNT, shift register 0, bit counters 0.
- **States: HUNT, BODY, PRE.**
- **HUNT.**
  - Every accepted bit (`bit_valid`=1) shifts into a 4-bit register `sr <= {sr[2:0],bit_in}`.
  - When `{sr[2:0],bit_in}` equals `PRE_B`: pulse `dis_rst`, set `frame_counter`=0, set `locked`=1, go to BODY with the body bit count at 0.
  - A match against `PRE_M` is ignored.
  - `dis_vin` stays 0.
- **BODY.**
  - Each accepted bit is forwarded as `dis_vin`=1, `dis_din`=`bit_in`, and the body count increments.
  - After body bit 27 is accepted, go to PRE with the preamble count at 0.
- **PRE.**
  - Accepted bits are collected and not forwarded.
  - On the first preamble bit, `frame_counter` advances: 191 wraps to 0, otherwise it increments.
  - On the fourth bit, the assembled pattern is compared with the expected preamble: `PRE_B` if `frame_counter`==0, else `PRE_M`.
  - Match: go to BODY.
  - Mismatch: framing error.
- **Framing error, `dis_kill`=1 in any locked state, or timeout:**
  - go to HUNT, set `locked`=0, pulse `dis_rst`, set `frame_counter`=0, clear `sr`.
  - The bit accepted in the same cycle is discarded and does not enter `sr`.
- **`dis_done`=1:** `block_count` increments, mod 2^16. It is counted even in the same cycle as `dis_kill`.
- **Simultaneous events:**
  - `dis_kill` together with a preamble mismatch counts as one error event.
  - `dis_kill` while in HUNT is ignored.
- **Timeout:** an idle counter of width $clog2(TIMEOUT+1) clears on every `bit_valid` and runs only while `locked`. Reaching `TIMEOUT` is an error event.

## Timing
- `dis_vin`/`dis_din` are registered: a bit accepted at edge t appears during cycle t+1, for exactly one cycle.
- `dis_rst` is registered and high for exactly one cycle, the cycle after the triggering bit or event. With back-to-back `bit_valid`, the first body `dis_vin` follows `dis_rst` in the next cycle, so the two never overlap.
- `frame_counter` changes only on the edge accepting the first preamble bit. `frame_dismantle` therefore sees the old index on body bit 27 (its PARITY check of frame 191) and the new index on body bit 0.
- `locked` rises together with the `dis_rst` pulse and falls on the edge after the error event.
- `bit_valid` may be asserted on every cycle or sparsely. Gaps do not affect counting.
- Asynchronous `rst` mid-subframe returns all outputs to 0 immediately. After deassertion the sequencer starts in HUNT.

## Configuration
- `FRAME_SEQ_ERRCNT_EN`.
  - Defined: adds output `err_count` (8 bits, reset 0). It increments once per error event (framing mismatch, `dis_kill`, timeout) and saturates at 255.
  - Undefined: the port and counter are absent. Error behaviour is otherwise identical.

## Test plan
- **Clean lock:** stream `PRE_B` then 28 body bits, then 191 × (`PRE_M` + 28 bits), all with `bit_valid`=1 every cycle.
  - `dis_rst` pulses once.
  - `dis_vin` is high on 5376 cycles.
  - `frame_counter` steps 0..191.
  - On `dis_done` pulse, `block_count`=1.
- **Frame wrap:** continue into a second block with `PRE_B`. `frame_counter` goes 191→0 with no error, and `locked` stays 1.
- **Bad preamble:** in frame 5, send `PRE_B` instead of `PRE_M`.
  - `locked`→0.
  - One `dis_rst` pulse.
  - `err_count`=1 with `FRAME_SEQ_ERRCNT_EN` defined.
  - The next valid `PRE_B` relocks.
- **Kill:** assert `dis_kill` during the body of frame 100.
  - HUNT with `frame_counter`=0.
  - `dis_vin` stays 0 until the next `PRE_B`.
  - `dis_kill` together with a mismatch gives `err_count`+1 only.
- **Sparse / timeout:** `bit_valid` every 3rd cycle keeps framing identical. Then hold `bit_valid`=0 for 1024 cycles while locked; `locked`→0 on the next edge.
- **Reset mid-body:** assert `rst` at body bit 12. All outputs are 0 the same cycle, and the sequencer relocks only after `PRE_B`.
